// File: rtl/asg_seq_pkg.sv
// Shared types and constants for the ASG segment sequencer.
// The descriptor struct is sized for RSZ up to 32; narrower channels zero-extend into it.
package asg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TRIG,
    WAIT_ON,
    RUN
  } seq_state_e;

  localparam int unsigned DESC_W = 48;

  typedef struct packed {
    logic [DESC_W-1:0] ofs;
    logic [DESC_W-1:0] size;
    logic [DESC_W-1:0] step;
    logic [15:0]       ncyc;
  } seg_desc_t;

  localparam int unsigned WDOG_LIMIT = 16;
  localparam int unsigned WDOG_W     = 5;

endpackage

// File: rtl/asg_seq_table.sv
// Segment descriptor storage: one synchronous write port, one asynchronous read port.
module asg_seq_table
  import asg_seq_pkg::*;
#(
  parameter int NSEG = 8
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [$clog2(NSEG)-1:0] waddr_i,
  input  seg_desc_t               wdata_i,
  input  logic [$clog2(NSEG)-1:0] raddr_i,
  output seg_desc_t               rdata_o
);

  seg_desc_t mem_q [NSEG];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/asg_seg_seq.sv
// Plays a table of ASG segment descriptors in order, handshaking with the channel FSM.
// Defining ASG_SEQ_WATCHDOG_EN adds a WAIT_ON timeout that sets a sticky err_o.
module asg_seg_seq
  import asg_seq_pkg::*;
#(
  parameter int RSZ  = 14,
  parameter int NSEG = 8
) (
  input  logic                    dac_clk_i,
  input  logic                    dac_rst_i,
  input  logic                    seg_we_i,
  input  logic [$clog2(NSEG)-1:0] seg_addr_i,
  input  logic [RSZ+15:0]         seg_ofs_i,
  input  logic [RSZ+15:0]         seg_size_i,
  input  logic [RSZ+15:0]         seg_step_i,
  input  logic [15:0]             seg_ncyc_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    loop_i,
  input  logic [$clog2(NSEG):0]   nseg_i,
  input  logic                    ch_busy_i,
  output logic [RSZ+15:0]         set_ofs_o,
  output logic [RSZ+15:0]         set_size_o,
  output logic [RSZ+15:0]         set_step_o,
  output logic [15:0]             set_ncyc_o,
  output logic                    set_rst_o,
  output logic                    trig_sw_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [$clog2(NSEG)-1:0] cur_seg_o
);

  localparam int IW = $clog2(NSEG);
  localparam int DW = RSZ + 16;

  seq_state_e    state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] cur_seg_q;
  logic [DW-1:0] ofs_q;
  logic [DW-1:0] size_q;
  logic [DW-1:0] step_q;
  logic [15:0]   ncyc_q;
  logic          set_rst_q;
  logic          trig_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
`ifdef ASG_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
`endif

  seg_desc_t   wr_desc_d;
  seg_desc_t   rd_desc_d;
  logic [IW:0] idx_inc_d;
  logic        start_ok_d;
  logic        more_d;
  logic        unused_desc_bits;

  assign wr_desc_d = '{ofs:  DESC_W'(seg_ofs_i),
                       size: DESC_W'(seg_size_i),
                       step: DESC_W'(seg_step_i),
                       ncyc: seg_ncyc_i};

  asg_seq_table #(
    .NSEG (NSEG)
  ) u_table (
    .clk_i   (dac_clk_i),
    .we_i    (seg_we_i),
    .waddr_i (seg_addr_i),
    .wdata_i (wr_desc_d),
    .raddr_i (idx_q),
    .rdata_o (rd_desc_d)
  );

  // The zero-extension headroom of the shared struct is never read back.
  assign unused_desc_bits = ^{rd_desc_d.ofs, rd_desc_d.size, rd_desc_d.step};

  assign idx_inc_d  = {1'b0, idx_q} + (IW+1)'(1);
  assign more_d     = idx_inc_d < nseg_i;
  assign start_ok_d = (nseg_i != '0) && (nseg_i <= (IW+1)'(NSEG));

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_seg_q <= '0;
      ofs_q     <= '0;
      size_q    <= '0;
      step_q    <= '0;
      ncyc_q    <= '0;
      set_rst_q <= 1'b1;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ASG_SEQ_WATCHDOG_EN
      wdog_q    <= '0;
`endif
    end else begin
      trig_q <= 1'b0;
      done_q <= 1'b0;
      // Stop outranks everything, including a simultaneous start.
      if (stop_i) begin
        state_q   <= IDLE;
        set_rst_q <= 1'b1;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            set_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            if (start_i && start_ok_d) begin
              idx_q   <= '0;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            ofs_q     <= rd_desc_d.ofs[DW-1:0];
            size_q    <= rd_desc_d.size[DW-1:0];
            step_q    <= rd_desc_d.step[DW-1:0];
            ncyc_q    <= rd_desc_d.ncyc;
            cur_seg_q <= idx_q;
            set_rst_q <= 1'b1;
            state_q   <= TRIG;
          end
          TRIG: begin
            set_rst_q <= 1'b0;
            trig_q    <= 1'b1;
            state_q   <= WAIT_ON;
`ifdef ASG_SEQ_WATCHDOG_EN
            wdog_q    <= '0;
`endif
          end
          WAIT_ON: begin
            if (ch_busy_i) begin
              state_q <= RUN;
            end
`ifdef ASG_SEQ_WATCHDOG_EN
            else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
              state_q   <= IDLE;
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              set_rst_q <= 1'b1;
            end else begin
              wdog_q <= wdog_q + WDOG_W'(1);
            end
`endif
          end
          RUN: begin
            // nseg_i and loop_i are deliberately sampled live at segment end.
            if (!ch_busy_i) begin
              if (more_d) begin
                idx_q     <= idx_inc_d[IW-1:0];
                set_rst_q <= 1'b1;
                state_q   <= LOAD;
              end else if (loop_i) begin
                idx_q     <= '0;
                set_rst_q <= 1'b1;
                state_q   <= LOAD;
              end else begin
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                set_rst_q <= 1'b1;
                state_q   <= IDLE;
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            set_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign set_ofs_o  = ofs_q;
  assign set_size_o = size_q;
  assign set_step_o = step_q;
  assign set_ncyc_o = ncyc_q;
  assign set_rst_o  = set_rst_q;
  assign trig_sw_o  = trig_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cur_seg_o  = cur_seg_q;

endmodule

// File: doc/asg_seg_seq.md
ASG_SEG_SEQ -- requirements
Module: asg_seg_seq

Interface
REQ-001 SHALL have parameter RSZ, default 14, meaning buffer address width of the driven ASG channel.
REQ-002 SHALL have parameter NSEG, default 8, meaning number of segment descriptors (power of two).
REQ-003 SHALL have port dac_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port dac_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port seg_we_i  in  1  descriptor write strobe.
REQ-006 SHALL have port seg_addr_i  in  log2(NSEG)  descriptor index written.
REQ-007 SHALL have ports seg_ofs_i, seg_size_i, seg_step_i  in  RSZ+16 each  descriptor offset, size and step (16.RSZ fixed point).
REQ-008 SHALL have port seg_ncyc_i  in  16  descriptor table-cycle count.
REQ-009 SHALL have ports start_i, stop_i, loop_i  in  1 each  start pulse, stop pulse and loop-enable level.
REQ-010 SHALL have port nseg_i  in  log2(NSEG)+1  number of segments to play (valid 1..NSEG).
REQ-011 SHALL have port ch_busy_i  in  1  channel playback active (channel cycle-mode flag).
REQ-012 SHALL have ports set_ofs_o, set_size_o, set_step_o  out  RSZ+16 each  to channel config; and set_ncyc_o  out  16.
REQ-013 SHALL have ports set_rst_o and trig_sw_o  out  1 each  channel FSM reset and software trigger.
REQ-014 SHALL have ports busy_o, done_o, err_o  out  1 each; and cur_seg_o  out  log2(NSEG)  index of the active segment.

Function
REQ-015 SHALL hold NSEG descriptors {ofs,size,step,ncyc}; seg_we_i writes index seg_addr_i in one cycle, also while running.
REQ-016 SHALL implement states IDLE, LOAD, TRIG, WAIT_ON, RUN; all outputs registered.
REQ-017 In IDLE, SHALL drive set_rst_o=1 and busy_o=0; start_i with nseg_i in 1..NSEG SHALL set idx=0 and go to LOAD; nseg_i=0 or >NSEG SHALL ignore start_i.
REQ-018 In LOAD, SHALL copy descriptor idx to set_*_o, keep set_rst_o=1, set cur_seg_o=idx, then go to TRIG.
REQ-019 In TRIG, SHALL drive set_rst_o=0 and trig_sw_o=1 for exactly one cycle, then go to WAIT_ON.
REQ-020 Latency: trig_sw_o SHALL be high exactly 3 cycles after the cycle in which start_i is sampled high.
REQ-021 In WAIT_ON, SHALL go to RUN on ch_busy_i=1.
REQ-022 In RUN, on ch_busy_i=0: if idx<nseg_i-1, SHALL do idx+1 and go to LOAD; at the last segment with loop_i=1, SHALL set idx=0 and go to LOAD; otherwise SHALL pulse done_o for one cycle and go to IDLE.
REQ-023 busy_o SHALL be 1 in every state except IDLE; start_i while busy_o=1 SHALL be ignored.
REQ-024 stop_i SHALL force IDLE on the next cycle from any state, assert set_rst_o and suppress done_o; stop_i together with start_i SHALL resolve to stop.
REQ-025 A descriptor write to the active index SHALL take effect only at that index's next LOAD; set_*_o SHALL change only in LOAD.
REQ-026 nseg_i and loop_i SHALL be sampled live; a change of nseg_i during playback SHALL apply at the next RUN exit.

Reset
REQ-027 On dac_rst_i=1: state=IDLE, idx=0, set_*_o=0, set_rst_o=1, trig_sw_o=0, busy_o=0, done_o=0, err_o=0, cur_seg_o=0; descriptor contents undefined.
REQ-028 Reset mid-playback SHALL return to IDLE on the next cycle, with no done_o pulse.

Configuration
REQ-029 With ASG_SEQ_WATCHDOG_EN defined, WAIT_ON SHALL count cycles; 16 cycles without ch_busy_i SHALL go to IDLE, set err_o (sticky until start_i or reset) and emit no done_o.
REQ-030 Without ASG_SEQ_WATCHDOG_EN, WAIT_ON SHALL wait indefinitely and err_o SHALL be constant 0.

Structure
REQ-031 Package asg_seq_pkg SHALL hold the state enum, the descriptor struct type and the watchdog limit constant (16).
REQ-032 Descriptor storage SHALL be sub-module asg_seq_table: one write port plus one asynchronous read port indexed by idx.

Verification
REQ-033 Reset, then start_i with nseg_i=1 and a model channel (busy 2 cycles after trig for 10 cycles) -> one trig_sw_o pulse 3 cycles after start, done_o one cycle after busy falls, set_rst_o back to 1.
REQ-034 nseg_i=3 with ofs 0x0, 0x10000, 0x20000 -> set_ofs_o steps through the three offsets in order, cur_seg_o 0,1,2, three trig_sw_o pulses, one done_o.
REQ-035 nseg_i=2, loop_i=1 for 3 passes, then loop_i=0 -> cur_seg_o 0,1,0,1,0,1, done_o after the 6th segment.
REQ-036 stop_i in RUN of segment 1, with start_i in the same cycle -> IDLE next cycle, set_rst_o=1, no done_o, no new trigger.
REQ-037 Write segment 0 while it plays -> the current set_ofs_o is unchanged, the new value appears at the next loop's LOAD.
REQ-038 With ASG_SEQ_WATCHDOG_EN, ch_busy_i held 0 -> IDLE 16 cycles after TRIG, err_o=1, done_o=0; err_o clears on the next start_i.
